pulse_pacer: RTL and testbench



---
 rtl/pulse_pacer.sv | 157 +++++++++++++++
 tb/tb_pulse_pacer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pulse_pacer.sv
// -----------------------------------------------------------------------------
// pulse_pacer
//   Counts single-cycle event pulses on i and re-emits them on o as one-cycle
//   pulses whose rising edges are at least GAP clocks apart. This lets a
//   toggle-based pulse synchronizer in a slower domain see every toggle.
//   Events are only lost when the pending counter is saturated.
//
// Parameters
//   GAP    : minimum clocks between successive o rising edges (2..255)
//   CNT_W  : pending-event counter width (max pending = 2^CNT_W-1)
//
// Ports
//   clk      in   source-domain clock
//   rst      in   asynchronous active-high reset
//   i        in   event input, one event per high cycle
//   o        out  paced one-cycle pulse (registered)
//   pending  out  events accepted but not yet emitted (registered)
//   busy     out  pending != 0 or FSM not idle
//   overflow out  sticky: event arrived while pending was at max
//   ovf_clr  in   clears overflow (set wins in the same cycle)
//
// Build option
//   PULSE_PACER_OVF_EN : when defined, overflow is a sticky flag cleared by
//   ovf_clr. When undefined, overflow is tied low and ovf_clr is ignored;
//   saturation still holds pending at max and drops the event.
// -----------------------------------------------------------------------------
module pulse_pacer #(
    parameter int GAP   = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    output logic             o,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow,
    input  logic             ovf_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [7:0]       GCNT_RLD = 8'(GAP - 2);

    state_t           state_q, state_d;
    logic [7:0]       gcnt_q, gcnt_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             o_q, o_d;
    logic             fire;
    logic             ovf_set;

    // A pulse may be launched from IDLE, or from WAIT once the gap has run
    // out; the source is either a stored event or the one arriving now.
    assign fire = ((state_q == IDLE) || ((state_q == WAIT) && (gcnt_q == 8'd0)))
                  && ((pend_q != '0) || i);

    // Next-state / output logic
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        o_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = PULSE;
                    o_d     = 1'b1;
                end
            end
            PULSE: begin
                // PULSE itself and the final gcnt==0 WAIT cycle account
                // for two of the GAP clocks, hence the GAP-2 reload.
                gcnt_d  = GCNT_RLD;
                state_d = WAIT;
            end
            WAIT: begin
                if (gcnt_q != 8'd0) begin
                    gcnt_d = gcnt_q - 8'd1;
                end else if (fire) begin
                    state_d = PULSE;
                    o_d     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gcnt_d  = 8'd0;
            end
        endcase
    end

    // Pending counter: +i -fire, saturating at max with the event dropped.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (i && !fire) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (fire && !i) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gcnt_q  <= 8'd0;
            pend_q  <= '0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            pend_q  <= pend_d;
            o_q     <= o_d;
        end
    end

`ifdef PULSE_PACER_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_set ^ ovf_clr;
    assign overflow   = 1'b0;
`endif

    assign o       = o_q;
    assign pending = pend_q;
    assign busy    = (pend_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_pulse_pacer.sv
// -----------------------------------------------------------------------------
// tb_pulse_pacer
//   Directed bench for pulse_pacer. Main instance uses GAP=6, CNT_W=3 so the
//   saturation case is reachable; a second instance runs GAP=2.
//   Inputs are driven and outputs sampled on the falling edge; "k" below is
//   the number of rising edges since the stimulus started.
// -----------------------------------------------------------------------------
module tb_pulse_pacer;

    logic       clk = 1'b0;
    logic       rst;
    logic       i, ovf_clr;
    logic       o, busy, overflow;
    logic [2:0] pending;

    logic       i2;
    logic       o2, busy2, ovf2;
    logic [7:0] pend2;

    int n_run  = 0;
    int n_fail = 0;
    int n_pulse = 0;

    always #5 clk = ~clk;

    pulse_pacer #(.GAP(6), .CNT_W(3)) u_dut (
        .clk(clk), .rst(rst), .i(i), .o(o), .pending(pending),
        .busy(busy), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    pulse_pacer #(.GAP(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .i(i2), .o(o2), .pending(pend2),
        .busy(busy2), .overflow(ovf2), .ovf_clr(1'b0)
    );

    // Free-running count of o pulses on the main instance.
    always @(posedge clk) if (o) n_pulse <= n_pulse + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] obits, emask;
        int base;
        logic ovf_exp;
`ifdef PULSE_PACER_OVF_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        rst = 1'b1; i = 1'b0; i2 = 1'b0; ovf_clr = 1'b0;
        repeat (2) tick;
        chk("rst_o", o, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2) tick;

        // Single event: o at k=1 only, busy k=1..6, low at k=7.
        i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            i = 1'b0;
            chk($sformatf("single_o_k%0d", k), o, (k == 1));
            chk($sformatf("single_busy_k%0d", k), busy, (k <= 6));
            chk($sformatf("single_pend_k%0d", k), pending, 0);
        end
        repeat (2) tick;

        // Event lands exactly on WAIT with gcnt==0 (k=6): o at k=7, pending 0.
        i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            i = (k == 6);
            chk($sformatf("simul_o_k%0d", k), o, (k == 1 || k == 7));
            chk($sformatf("simul_pend_k%0d", k), pending, 0);
        end
        repeat (8) tick;

        // Burst of 4: o at k=1,7,13,19; pending 3 at k=4, 0 at k=19.
        obits = '0;
        i = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick;
            obits[k] = o;
            if (k == 4)  chk("burst_pend_peak", pending, 3);
            if (k == 19) chk("burst_pend_end", pending, 0);
            i = (k < 4);
        end
        emask = '0;
        emask[1] = 1'b1; emask[7] = 1'b1; emask[13] = 1'b1; emask[19] = 1'b1;
        chk("burst_o_pattern", obits, emask);
        repeat (4) tick;
        chk("burst_idle", busy, 0);

        // GAP=2, six events: o2 at k=1,3,5,7,9,11.
        obits = '0;
        i2 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick;
            obits[k] = o2;
            if (k == 6) chk("gap2_pend_k6", pend2, 3);
            i2 = (k < 6);
        end
        emask = 32'h0000_0AAA;
        chk("gap2_o_pattern", obits, emask);
        chk("gap2_idle", busy2, 0);

        // Saturation: 20 events into a 3-bit counter, 9 dropped.
        base = n_pulse;
        i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 9)  chk("sat_ovf_before", overflow, 0);
            if (k == 9)  chk("sat_pend_k9", pending, 7);
            if (k == 20) chk("sat_pend_clamp", pending, 7);
            i = (k < 20);
        end
        chk("sat_overflow", overflow, ovf_exp);
        for (int c = 0; c < 100; c++) begin
            tick;
            if (!busy) break;
        end
        chk("sat_drain_busy", busy, 0);
        tick;
        chk("sat_pulse_total", n_pulse - base, 11);
        chk("sat_ovf_held", overflow, ovf_exp);
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        chk("sat_ovf_clr", overflow, 0);
        tick;

        // Reset mid-burst with pending=3.
        i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            i = (k < 4);
        end
        chk("rstmid_pend_before", pending, 3);
        rst = 1'b1;
        #1;
        chk("rstmid_o", o, 0);
        chk("rstmid_pending", pending, 0);
        chk("rstmid_busy", busy, 0);
        tick;
        rst = 1'b0;
        base = n_pulse;
        repeat (10) tick;
        chk("rstmid_no_pulse", n_pulse - base, 0);
        chk("rstmid_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
